// File: rtl/easyaxi_rd_mst.sv
// AXI read master. Issues NUM_REQ single-ID-per-request AR bursts, keeps up to
// OST_DEPTH of them outstanding, and checks returning R beats in order against a
// tracker FIFO of {id, len}.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   enable                     start a run (sampled in IDLE); drop to leave DONE
//   axi_mst_ar*                AR channel (valid/ready/id/addr/len/size/burst)
//   axi_mst_r*                 R channel (valid/ready/id/data/resp/last)
//   mst_done                   run finished, held until enable low
//   mst_err                    sticky ordering/protocol check failure
//   mst_resp_err_cnt           non-OKAY rlast beats, saturating at 255

`ifndef AXI_ID_W
`define AXI_ID_W       4
`define AXI_ADDR_W     32
`define AXI_LEN_W      8
`define AXI_SIZE_W     3
`define AXI_BURST_W    2
`define AXI_DATA_W     32
`define AXI_RESP_W     2
`define AXI_SIZE_1B    3'b000
`define AXI_BURST_INCR 2'b01
`define AXI_RESP_OKAY  2'b00
`endif

module easyaxi_rd_mst #(
  parameter int unsigned             OST_DEPTH = 8,
  parameter int unsigned             NUM_REQ   = 16,
  parameter logic [`AXI_ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [`AXI_ADDR_W-1:0]  ADDR_STEP = '0,
  parameter logic [`AXI_SIZE_W-1:0]  ARSIZE    = `AXI_SIZE_1B
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      axi_mst_arvalid,
  input  logic                      axi_mst_arready,
  output logic [`AXI_ID_W-1:0]      axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]    axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]     axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]    axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0]   axi_mst_arburst,
  input  logic                      axi_mst_rvalid,
  output logic                      axi_mst_rready,
  input  logic [`AXI_ID_W-1:0]      axi_mst_rid,
  input  logic [`AXI_DATA_W-1:0]    axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]    axi_mst_rresp,
  input  logic                      axi_mst_rlast,
  output logic                      mst_done,
  output logic                      mst_err,
  output logic [7:0]                mst_resp_err_cnt
);

  localparam int unsigned PtrW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdW  = `AXI_ID_W;
  localparam int unsigned LenW = `AXI_LEN_W;
  localparam logic [CntW-1:0] OstMax = CntW'(OST_DEPTH);
  localparam logic [7:0]      NumReq = 8'(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              req_cnt_q, req_cnt_d;
  logic [CntW-1:0]         ost_cnt_q, ost_cnt_d;
  logic [LenW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [`AXI_ADDR_W-1:0]  addr_q, addr_d;
  logic                    err_q, err_d;
  logic [7:0]              resp_err_cnt_q, resp_err_cnt_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  logic [IdW-1:0]          trk_id  [OST_DEPTH];
  logic [LenW-1:0]         trk_len [OST_DEPTH];

  logic ar_hs, r_hs, push, pop;
  logic [IdW-1:0]  head_id;
  logic [LenW-1:0] head_len;

  // Payload is held in the request counter, so it cannot change until a handshake.
  assign axi_mst_arvalid  = arvalid_q;
  assign axi_mst_arid     = req_cnt_q[IdW-1:0];
  assign axi_mst_araddr   = addr_q;
  assign axi_mst_arlen    = LenW'(req_cnt_q[2:0]);
  assign axi_mst_arsize   = ARSIZE;
  assign axi_mst_arburst  = `AXI_BURST_INCR;
  assign axi_mst_rready   = rready_q;
  assign mst_done         = (state_q == StDone);
  assign mst_err          = err_q;
  assign mst_resp_err_cnt = resp_err_cnt_q;

  assign ar_hs    = arvalid_q & axi_mst_arready;
  assign r_hs     = axi_mst_rvalid & rready_q;
  assign head_id  = trk_id[rd_ptr_q];
  assign head_len = trk_len[rd_ptr_q];

  logic unused_rdata;
  assign unused_rdata = ^axi_mst_rdata;

  always_comb begin
    state_d        = state_q;
    req_cnt_d      = req_cnt_q;
    ost_cnt_d      = ost_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    addr_d         = addr_q;
    err_d          = err_q;
    resp_err_cnt_d = resp_err_cnt_q;
    push           = 1'b0;
    pop            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d        = StRun;
          req_cnt_d      = '0;
          ost_cnt_d      = '0;
          beat_cnt_d     = '0;
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          addr_d         = BASE_ADDR;
          err_d          = 1'b0;
          resp_err_cnt_d = '0;
        end
      end
      StRun: begin
        if (ar_hs) begin
          push      = 1'b1;
          req_cnt_d = req_cnt_q + 8'd1;
          addr_d    = addr_q + ADDR_STEP;
          wr_ptr_d  = wr_ptr_q + PtrW'(1);
        end
        if (r_hs) begin
          if (ost_cnt_q == '0) begin
            // Nothing outstanding: flag and drop the beat.
            err_d = 1'b1;
          end else begin
            if (axi_mst_rid != head_id) err_d = 1'b1;
            if (axi_mst_rlast != (beat_cnt_q == head_len)) err_d = 1'b1;
            if (axi_mst_rlast) begin
              // An early rlast still retires the head so later bursts stay aligned.
              pop        = 1'b1;
              beat_cnt_d = '0;
              rd_ptr_d   = rd_ptr_q + PtrW'(1);
              if (axi_mst_rresp != `AXI_RESP_OKAY && resp_err_cnt_q != 8'hFF) begin
                resp_err_cnt_d = resp_err_cnt_q + 8'd1;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + LenW'(1);
            end
          end
        end
        if (push && !pop) begin
          ost_cnt_d = ost_cnt_q + CntW'(1);
        end else if (!push && pop) begin
          ost_cnt_d = ost_cnt_q - CntW'(1);
        end
        if (req_cnt_q == NumReq && ost_cnt_q == '0) state_d = StDone;
      end
      StDone: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered from next-state values: arvalid rises the cycle after enable is
  // seen and never depends combinationally on arready.
  always_comb begin
    arvalid_d = (state_d == StRun) && (req_cnt_d < NumReq) && (ost_cnt_d < OstMax);
    rready_d  = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_cnt_q      <= '0;
      ost_cnt_q      <= '0;
      beat_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      addr_q         <= BASE_ADDR;
      err_q          <= 1'b0;
      resp_err_cnt_q <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_cnt_q      <= req_cnt_d;
      ost_cnt_q      <= ost_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      addr_q         <= addr_d;
      err_q          <= err_d;
      resp_err_cnt_q <= resp_err_cnt_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
    end
  end

  // Tracker storage needs no reset; validity is defined by ost_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      trk_id[wr_ptr_q]  <= axi_mst_arid;
      trk_len[wr_ptr_q] <= axi_mst_arlen;
    end
  end

endmodule
